// File: rtl/botao_eventos_if.sv
// Button event bus: debounced level in, classified event pulses out.
interface botao_eventos_if;
    logic botao_debouce;
    logic pulso_curto;
    logic pulso_longo;
    logic pulso_repeticao;
    logic pressionado;

    // Side that drives the button level and consumes the events
    modport master (
        output botao_debouce,
        input  pulso_curto,
        input  pulso_longo,
        input  pulso_repeticao,
        input  pressionado
    );

    // Side that classifies the button level into events
    modport slave (
        input  botao_debouce,
        output pulso_curto,
        output pulso_longo,
        output pulso_repeticao,
        output pressionado
    );
endinterface

// File: rtl/botao_eventos.sv
// Button event classifier: turns the debounced button level into one-cycle
// short-press, long-press and auto-repeat pulses plus a registered "held" level.
module botao_eventos #(
    parameter int unsigned LONGO_CICLOS  = 25000000,
    parameter int unsigned REPETE_CICLOS = 5000000,
    parameter int unsigned CONT_W        = 25
) (
    input  logic              clk,
    input  logic              rst,
    botao_eventos_if.slave    bus
);

    typedef enum logic [1:0] {
        OCIOSO      = 2'b00,
        PRESSIONADO = 2'b01,
        REPETINDO   = 2'b10,
        INVALIDO    = 2'b11
    } estado_t;

    localparam logic [CONT_W-1:0] LONGO_FIM  = CONT_W'(LONGO_CICLOS - 1);
    localparam logic [CONT_W-1:0] REPETE_FIM = CONT_W'(REPETE_CICLOS - 1);
    localparam logic [CONT_W-1:0] CONT_UM    = CONT_W'(1);

    estado_t           estado_q, estado_d;
    logic [CONT_W-1:0] cont_q, cont_d;
    logic              botao_ant_q, botao_ant_d;
    logic              pulso_curto_q, pulso_curto_d;
    logic              pulso_longo_q, pulso_longo_d;
    logic              pulso_repeticao_q, pulso_repeticao_d;
    logic              pressionado_q, pressionado_d;

    // State, counter and output registers; botao_ant resets high so a button
    // already held at reset release must be seen low before it counts.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            estado_q          <= OCIOSO;
            cont_q            <= '0;
            botao_ant_q       <= 1'b1;
            pulso_curto_q     <= 1'b0;
            pulso_longo_q     <= 1'b0;
            pulso_repeticao_q <= 1'b0;
            pressionado_q     <= 1'b0;
        end else begin
            estado_q          <= estado_d;
            cont_q            <= cont_d;
            botao_ant_q       <= botao_ant_d;
            pulso_curto_q     <= pulso_curto_d;
            pulso_longo_q     <= pulso_longo_d;
            pulso_repeticao_q <= pulso_repeticao_d;
            pressionado_q     <= pressionado_d;
        end
    end

    // Next-state, counter and pulse decode; release has priority over the
    // terminal count so a release on the threshold edge is a short press.
    always_comb begin
        estado_d          = estado_q;
        cont_d            = cont_q;
        botao_ant_d       = bus.botao_debouce;
        pulso_curto_d     = 1'b0;
        pulso_longo_d     = 1'b0;
        pulso_repeticao_d = 1'b0;

        case (estado_q)
            OCIOSO: begin
                if (bus.botao_debouce && !botao_ant_q) begin
                    estado_d = PRESSIONADO;
                    cont_d   = '0;
                end
            end
            PRESSIONADO: begin
                if (!bus.botao_debouce) begin
                    pulso_curto_d = 1'b1;
                    estado_d      = OCIOSO;
                    cont_d        = '0;
                end else if (cont_q == LONGO_FIM) begin
                    pulso_longo_d = 1'b1;
                    estado_d      = REPETINDO;
                    cont_d        = '0;
                end else begin
                    cont_d = cont_q + CONT_UM;
                end
            end
            REPETINDO: begin
                if (!bus.botao_debouce) begin
                    estado_d = OCIOSO;
                    cont_d   = '0;
                end else if (cont_q == REPETE_FIM) begin
                    pulso_repeticao_d = 1'b1;
                    cont_d            = '0;
                end else begin
                    cont_d = cont_q + CONT_UM;
                end
            end
            default: begin
                estado_d = OCIOSO;
                cont_d   = '0;
            end
        endcase

        // Registered from the next state so it rises on the press-detect edge
        pressionado_d = (estado_d != OCIOSO);
    end

    assign bus.pulso_curto     = pulso_curto_q;
    assign bus.pulso_longo     = pulso_longo_q;
    assign bus.pulso_repeticao = pulso_repeticao_q;
    assign bus.pressionado     = pressionado_q;

endmodule

// File: tb/tb_botao_eventos.sv
// Directed bench for botao_eventos with LONGO_CICLOS=8, REPETE_CICLOS=3.
// Observed vector order: {pulso_curto, pulso_longo, pulso_repeticao, pressionado}.
module tb_botao_eventos;

    logic clk;
    logic rst;
    int   vetores;
    int   erros;

    botao_eventos_if bus ();

    botao_eventos #(
        .LONGO_CICLOS  (8),
        .REPETE_CICLOS (3),
        .CONT_W        (3)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [3:0] saidas();
        return {bus.pulso_curto, bus.pulso_longo, bus.pulso_repeticao, bus.pressionado};
    endfunction

    task automatic chk(input string tag, input logic [3:0] esperado);
        logic [3:0] obs;
        obs = saidas();
        vetores++;
        assert (obs === esperado)
        else begin
            erros++;
            $error("FAIL %s: observed %b expected %b", tag, obs, esperado);
        end
    endtask

    // Drive the level for the next edge, clock once, then check 1 time unit after the edge
    task automatic step(input logic din, input logic [3:0] esperado, input string tag);
        bus.botao_debouce = din;
        @(posedge clk);
        #1;
        chk(tag, esperado);
    endtask

    initial begin
        vetores = 0;
        erros   = 0;
        rst = 1'b1;
        bus.botao_debouce = 1'b1;
        #1;
        chk("reset_state", 4'b0000);
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("reset_held", 4'b0000);
        rst = 1'b0;

        // Held through reset release: ignored until seen low
        for (int i = 0; i < 20; i++) step(1'b1, 4'b0000, $sformatf("held_rst_%0d", i));
        step(1'b0, 4'b0000, "held_rel_0");
        step(1'b0, 4'b0000, "held_rel_1");
        step(1'b1, 4'b0001, "held_press_0");
        step(1'b1, 4'b0001, "held_press_1");
        step(1'b1, 4'b0001, "held_press_2");
        step(1'b0, 4'b1000, "held_curto");
        step(1'b0, 4'b0000, "held_after");

        // Short press of 4 cycles
        step(1'b1, 4'b0001, "curto_p0");
        step(1'b1, 4'b0001, "curto_p1");
        step(1'b1, 4'b0001, "curto_p2");
        step(1'b1, 4'b0001, "curto_p3");
        step(1'b0, 4'b1000, "curto_pulse");
        step(1'b0, 4'b0000, "curto_after");

        // Long hold: long at edge 8 after detect, repeats at 11, 14, 17, 20
        for (int k = 0; k <= 20; k++) begin
            logic [3:0] e;
            e = 4'b0001;
            if (k == 8) e = 4'b0101;
            if (k == 11 || k == 14 || k == 17 || k == 20) e = 4'b0011;
            step(1'b1, e, $sformatf("longo_e%0d", k));
        end
        step(1'b0, 4'b0000, "longo_release");
        step(1'b0, 4'b0000, "longo_after");

        // Release on the edge where cont==7: short pulse only
        step(1'b1, 4'b0001, "limiar_e0");
        for (int k = 1; k <= 7; k++) step(1'b1, 4'b0001, $sformatf("limiar_e%0d", k));
        step(1'b0, 4'b1000, "limiar_curto");
        step(1'b0, 4'b0000, "limiar_after");

        // Reset while repeating
        for (int k = 0; k <= 7; k++) step(1'b1, 4'b0001, $sformatf("rstrep_e%0d", k));
        step(1'b1, 4'b0101, "rstrep_longo");
        step(1'b1, 4'b0001, "rstrep_e9");
        #2;
        rst = 1'b1;
        #1;
        chk("rstrep_async", 4'b0000);
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 15; i++) step(1'b1, 4'b0000, $sformatf("rstrep_held_%0d", i));
        step(1'b0, 4'b0000, "rstrep_rel_0");
        step(1'b0, 4'b0000, "rstrep_rel_1");

        // Back-to-back 2-cycle presses with one low cycle between
        step(1'b1, 4'b0001, "b2b_a0");
        step(1'b1, 4'b0001, "b2b_a1");
        step(1'b0, 4'b1000, "b2b_curto_a");
        step(1'b1, 4'b0001, "b2b_b0");
        step(1'b1, 4'b0001, "b2b_b1");
        step(1'b0, 4'b1000, "b2b_curto_b");
        step(1'b0, 4'b0000, "b2b_after");

        $display("== %0d vectors applied, %0d miscompares ==", vetores, erros);
        $finish;
    end

endmodule
